hazard_unit: RTL and testbench

//  Feedback-side control for the 5-stage pipeline: watches the execute-register outputs and the decode

---
 rtl/hazard_unit.sv | 124 ++++++++++++
 tb/tb_hazard_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage pipeline: EX forwarding selects, load-use
// stall, redirect flush, a small state tracker and saturating event counters.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       HzState,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } hz_state_t;

   hz_state_t  state, state_next;
   logic [4:0] rd_m, rd_w;
   logic       reg_write_m, reg_write_w;
   logic       lw_stall;

   // Select M (10) over W (01); x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] rdm, input logic wem,
                                          input logic [4:0] rdw, input logic wew);
      if (wem && rdm != 5'd0 && rdm == src)
         return 2'b10;
      else if (wew && rdw != 5'd0 && rdw == src)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Shadow copy of the M/W destination fields, one stage per edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_m        <= '0;
         rd_w        <= '0;
         reg_write_m <= 1'b0;
         reg_write_w <= 1'b0;
      end else begin
         rd_m        <= RdE;
         reg_write_m <= RegWriteE;
         rd_w        <= rd_m;
         reg_write_w <= reg_write_m;
      end
   end

   // Load in E whose destination is read by the instruction in D.
   always_comb begin
      lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   end

   // Forwarding and stall/flush controls; a redirect overrides a load-use stall.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (RST) begin
         ForwardAE = fwd_sel(Rs1E, rd_m, reg_write_m, rd_w, reg_write_w);
         ForwardBE = fwd_sel(Rs2E, rd_m, reg_write_m, rd_w, reg_write_w);
         if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         state <= RUN;
      else
         state <= state_next;
   end

   // Next state follows the event seen in the current cycle.
   always_comb begin
      state_next = RUN;
      if (PCSrcE)
         state_next = FLUSH;
      else if (lw_stall)
         state_next = STALL;
   end

   assign HzState = state;

   // Saturating event counters.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (lw_stall && !PCSrcE && StallCnt != '1)
            StallCnt <= StallCnt + CNT_W'(1);
         if (PCSrcE && FlushCnt != '1)
            FlushCnt <= FlushCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes expected responses from a
// rule-level reference model; a negedge monitor pops and compares.
module tb_hazard_unit;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
   logic       RegWriteE = 1'b0;
   logic [1:0] ResultSrcE = '0;
   logic       PCSrcE = 1'b0;

   logic [1:0]  fa, fb, hz, fa4, fb4, hz4;
   logic        sf, sd, fd, fe, sf4, sd4, fd4, fe4;
   logic [15:0] scnt, fcnt;
   logic [3:0]  scnt4, fcnt4;

   always #5 CLK = ~CLK;

   hazard_unit #(.CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .FlushD(fd),
      .FlushE(fe), .HzState(hz), .StallCnt(scnt), .FlushCnt(fcnt)
   );

   hazard_unit #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .FlushD(fd4),
      .FlushE(fe4), .HzState(hz4), .StallCnt(scnt4), .FlushCnt(fcnt4)
   );

   typedef struct {
      int fa, fb, sf, sd, fd, fe, hz, sc, fc, sc4, fc4;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: history of the last two E-stage writers, event counts.
   int m_rd = 0, w_rd = 0, m_we = 0, w_we = 0;
   int hz_m = 0, sc = 0, fc = 0, sc4 = 0, fc4 = 0;

   function automatic bit is_lw_stall();
      return (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
   endfunction

   function automatic int fwd(input int src);
      if (m_we != 0 && m_rd != 0 && m_rd == src) return 2;
      if (w_we != 0 && w_rd != 0 && w_rd == src) return 1;
      return 0;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v + 1 > maxv) ? maxv : v + 1;
   endfunction

   task automatic model_edge();
      bit lw;
      if (RST) begin
         lw   = is_lw_stall();
         w_rd = m_rd;  w_we = m_we;
         m_rd = RdE;   m_we = RegWriteE;
         hz_m = PCSrcE ? 2 : (lw ? 1 : 0);
         if (PCSrcE) begin
            fc  = sat(fc, 65535);
            fc4 = sat(fc4, 15);
         end else if (lw) begin
            sc  = sat(sc, 65535);
            sc4 = sat(sc4, 15);
         end
      end
   endtask

   task automatic apply(input bit rst, input int rs1d, input int rs2d, input int rs1e,
                        input int rs2e, input int rde, input bit we, input int rsrc,
                        input bit pcs);
      exp_t e;
      bit   lw;
      RST = rst; Rs1D = 5'(rs1d); Rs2D = 5'(rs2d); Rs1E = 5'(rs1e); Rs2E = 5'(rs2e);
      RdE = 5'(rde); RegWriteE = we; ResultSrcE = 2'(rsrc); PCSrcE = pcs;
      if (!rst) begin
         m_rd = 0; w_rd = 0; m_we = 0; w_we = 0;
         hz_m = 0; sc = 0; fc = 0; sc4 = 0; fc4 = 0;
      end
      #1;
      e = '{default: 0};
      e.hz = hz_m; e.sc = sc; e.fc = fc; e.sc4 = sc4; e.fc4 = fc4;
      if (rst) begin
         lw   = is_lw_stall();
         e.fa = fwd(rs1e);
         e.fb = fwd(rs2e);
         if (pcs) begin
            e.fd = 1; e.fe = 1;
         end else if (lw) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
         end
      end
      sb.push_back(e);
   endtask

   task automatic cycle(input bit rst, input int rs1d, input int rs2d, input int rs1e,
                        input int rs2e, input int rde, input bit we, input int rsrc,
                        input bit pcs);
      @(posedge CLK);
      model_edge();
      #1;
      apply(rst, rs1d, rs2d, rs1e, rs2e, rde, we, rsrc, pcs);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: compare both instances against each queued expectation.
   always @(negedge CLK) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk("ForwardAE", int'(fa), e.fa);
         chk("ForwardBE", int'(fb), e.fb);
         chk("StallF",    int'(sf), e.sf);
         chk("StallD",    int'(sd), e.sd);
         chk("FlushD",    int'(fd), e.fd);
         chk("FlushE",    int'(fe), e.fe);
         chk("HzState",   int'(hz), e.hz);
         chk("StallCnt",  int'(scnt), e.sc);
         chk("FlushCnt",  int'(fcnt), e.fc);
         chk("ForwardAE4", int'(fa4), e.fa);
         chk("ForwardBE4", int'(fb4), e.fb);
         chk("Ctrl4", int'({sf4, sd4, fd4, fe4}), (e.sf << 3) | (e.sd << 2) | (e.fd << 1) | e.fe);
         chk("HzState4",  int'(hz4), e.hz);
         chk("StallCnt4", int'(scnt4), e.sc4);
         chk("FlushCnt4", int'(fcnt4), e.fc4);
      end
   end

   initial begin
      // Reset with redirect and load-use inputs active.
      #1 apply(0, 7, 7, 3, 3, 7, 1, 1, 1);
      cycle(0, 7, 7, 3, 3, 7, 1, 1, 1);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Forwarding: add x5, consumer sees M then W.
      cycle(1, 0, 0, 0, 0, 5, 1, 0, 0);
      cycle(1, 0, 0, 5, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 5, 0, 0, 1, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Load-use: load x7, bubble, dependent reads x7 from W.
      cycle(1, 0, 7, 0, 0, 7, 1, 1, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 7, 0, 0, 0, 0);
      // Redirect and load-use together.
      cycle(1, 7, 0, 0, 0, 7, 1, 1, 1);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // M priority over W.
      cycle(1, 0, 0, 0, 0, 3, 1, 0, 0);
      cycle(1, 0, 0, 0, 0, 3, 1, 0, 0);
      cycle(1, 0, 0, 3, 3, 0, 0, 0, 0);
      // 20 load-use events saturate the 4-bit counter; reset mid-stall.
      repeat (20) cycle(1, 0, 7, 0, 0, 7, 1, 1, 0);
      cycle(1, 0, 7, 0, 0, 7, 1, 1, 0);
      cycle(0, 0, 7, 0, 0, 7, 1, 1, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Randomized traffic over a small register window.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 49) != 0),
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 1),
               ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(0, 3),
               ($urandom_range(0, 5) == 0));
      end
      @(posedge CLK);
      @(posedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
